// File: rtl/param_icache_pkg.sv
// Shared types and geometry helpers for the parametrised instruction cache.
// The address is split as {tag, set index, word offset, byte offset}.
package param_icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RESP,
        MEM_REQ,
        RECV,
        FILL,
        FLUSH
    } state_t;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the I-cache: tag+line storage with a registered read port, a
// write port and per-set valid bits that can be cleared one set at a time.
module icache_way
    import param_icache_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = idx_w(SETS),
    parameter int LINE_BITS  = 32 * LINE_WORDS
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic                 clr_en,
    input  logic [IDX_W-1:0]     clr_idx
);

    logic [TAG_W+LINE_BITS-1:0] mem [SETS];
    logic [TAG_W+LINE_BITS-1:0] rd_word_reg;
    logic [SETS-1:0]            valid_reg;
    logic                       rd_valid_reg;

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= {wr_tag, wr_line};
        end
        if (rd_en) begin
            rd_word_reg <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (clr_en) begin
                valid_reg[clr_idx] <= 1'b0;
            end
            if (wr_en) begin
                valid_reg[wr_idx] <= 1'b1;
            end
            if (rd_en) begin
                rd_valid_reg <= valid_reg[rd_idx];
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_tag   = rd_word_reg[TAG_W+LINE_BITS-1:LINE_BITS];
    assign rd_line  = rd_word_reg[LINE_BITS-1:0];

endmodule

// File: rtl/param_icache.sv
// Set-associative read-only instruction cache with round-robin replacement,
// burst line refill, critical-word return, flush sweep and hit/miss counters.
module param_icache
    import param_icache_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              from_cpu_inst_req_valid,
    input  logic [ADDR_W-1:0] from_cpu_inst_req_addr,
    output logic              to_cpu_inst_req_ready,
    output logic              to_cpu_cache_rsp_valid,
    output logic [31:0]       to_cpu_cache_rsp_data,
    input  logic              from_cpu_cache_rsp_ready,
    output logic              to_mem_rd_req_valid,
    output logic [ADDR_W-1:0] to_mem_rd_req_addr,
    input  logic              from_mem_rd_req_ready,
    input  logic              from_mem_rd_rsp_valid,
    input  logic [31:0]       from_mem_rd_rsp_data,
    input  logic              from_mem_rd_rsp_last,
    output logic              to_mem_rd_rsp_ready,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int IDX_W     = idx_w(SETS);
    localparam int OFF_W     = off_w(LINE_WORDS);
    localparam int TAG_W     = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int WAY_W     = $clog2(WAYS);
    localparam int LB_W      = OFF_W + 2;
    localparam int LINE_BITS = 32 * LINE_WORDS;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   req_addr_reg;
    logic [31:0]         rsp_data_reg;
    logic [WAY_W-1:0]    victim_reg;
    logic                evict_valid_reg;
    logic [OFF_W-1:0]    beat_cnt_reg;
    logic                beat_full_reg;
    logic [IDX_W-1:0]    flush_idx_reg;
    logic [31:0]         hit_cnt_reg, miss_cnt_reg;
    logic [WAY_W-1:0]    rr_ptr_reg [SETS];
    logic [31:0]         fill_buf_reg [LINE_WORDS];

    logic [OFF_W-1:0]    req_off;
    logic [IDX_W-1:0]    req_idx, live_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [WAYS-1:0]     way_valid, hit_vec;
    logic [TAG_W-1:0]    way_tag  [WAYS];
    logic [LINE_BITS-1:0] way_line [WAYS];
    logic [LINE_BITS-1:0] hit_line, fill_line;
    logic [31:0]         hit_word;
    logic [WAY_W-1:0]    victim_next;
    logic                victim_was_valid;
    logic                lookup_hit, accept, fill_we, flush_clr, beat_we, flush_last;
    logic                unused_lsbs;

    assign req_off     = req_addr_reg[LB_W-1:2];
    assign req_idx     = req_addr_reg[LB_W+IDX_W-1:LB_W];
    assign req_tag     = req_addr_reg[ADDR_W-1:LB_W+IDX_W];
    assign live_idx    = from_cpu_inst_req_addr[LB_W+IDX_W-1:LB_W];
    assign unused_lsbs = ^req_addr_reg[1:0];

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (accept),
            .rd_idx   (live_idx),
            .rd_valid (way_valid[gi]),
            .rd_tag   (way_tag[gi]),
            .rd_line  (way_line[gi]),
            .wr_en    (fill_we && (victim_reg == WAY_W'(gi))),
            .wr_idx   (req_idx),
            .wr_tag   (req_tag),
            .wr_line  (fill_line),
            .clr_en   (flush_clr),
            .clr_idx  (flush_idx_reg)
        );
        assign hit_vec[gi] = way_valid[gi] && (way_tag[gi] == req_tag);
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_fill_line
        assign fill_line[gi*32 +: 32] = fill_buf_reg[gi];
    end

    assign lookup_hit = |hit_vec;
    assign hit_word   = hit_line[{req_off, 5'b0} +: 32];
    assign flush_last = (flush_idx_reg == IDX_W'(SETS - 1));

    always_comb begin
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_line = hit_line | way_line[w];
            end
        end
    end

    // Lowest invalid way wins; only a full set falls back to the round-robin pointer.
    always_comb begin
        victim_next      = rr_ptr_reg[req_idx];
        victim_was_valid = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim_next      = w[WAY_W-1:0];
                victim_was_valid = 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        fill_we    = 1'b0;
        flush_clr  = 1'b0;
        beat_we    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else if (from_cpu_inst_req_valid && to_cpu_inst_req_ready) begin
                    accept     = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP:  state_next = lookup_hit ? RESP : MEM_REQ;
            MEM_REQ: if (from_mem_rd_req_ready) state_next = RECV;
            RECV: begin
                beat_we = from_mem_rd_rsp_valid && !beat_full_reg;
                if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                fill_we    = 1'b1;
                state_next = RESP;
            end
            RESP: if (from_cpu_cache_rsp_ready) state_next = IDLE;
            FLUSH: begin
                flush_clr = 1'b1;
                if (flush_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            req_addr_reg    <= '0;
            rsp_data_reg    <= '0;
            victim_reg      <= '0;
            evict_valid_reg <= 1'b0;
            beat_cnt_reg    <= '0;
            beat_full_reg   <= 1'b0;
            flush_idx_reg   <= '0;
            hit_cnt_reg     <= '0;
            miss_cnt_reg    <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_ptr_reg[s] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (accept) begin
                req_addr_reg <= from_cpu_inst_req_addr;
            end
            case (state_reg)
                IDLE: flush_idx_reg <= '0;
                LOOKUP: begin
                    if (lookup_hit) begin
                        rsp_data_reg <= hit_word;
                        hit_cnt_reg  <= hit_cnt_reg + 32'd1;
                    end else begin
                        miss_cnt_reg    <= miss_cnt_reg + 32'd1;
                        victim_reg      <= victim_next;
                        evict_valid_reg <= victim_was_valid;
                    end
                end
                MEM_REQ: begin
                    beat_cnt_reg  <= '0;
                    beat_full_reg <= 1'b0;
                end
                RECV: begin
                    if (beat_we) begin
                        if (beat_cnt_reg == OFF_W'(LINE_WORDS - 1)) begin
                            beat_full_reg <= 1'b1;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                FILL: begin
                    rsp_data_reg <= fill_buf_reg[req_off];
                    if (evict_valid_reg) begin
                        rr_ptr_reg[req_idx] <= rr_ptr_reg[req_idx] + 1'b1;
                    end
                end
                FLUSH: begin
                    rr_ptr_reg[flush_idx_reg] <= '0;
                    flush_idx_reg             <= flush_idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) begin
            fill_buf_reg[beat_cnt_reg] <= from_mem_rd_rsp_data;
        end
    end

    // While reset is held the memory side keeps accepting beats so a burst drains.
    assign to_cpu_inst_req_ready  = !rst && (state_reg == IDLE) && !flush_req;
    assign to_cpu_cache_rsp_valid = (state_reg == RESP);
    assign to_cpu_cache_rsp_data  = rsp_data_reg;
    assign to_mem_rd_req_valid    = (state_reg == MEM_REQ);
    assign to_mem_rd_req_addr     = (state_reg == MEM_REQ) ?
                                    {req_addr_reg[ADDR_W-1:LB_W], {LB_W{1'b0}}} : '0;
    assign to_mem_rd_rsp_ready    = rst || (state_reg == RECV);
    assign flush_done             = (state_reg == FLUSH) && flush_last;
    assign hit_cnt                = hit_cnt_reg;
    assign miss_cnt               = miss_cnt_reg;

endmodule

// File: tb/tb_param_icache.sv
// Scoreboard bench for param_icache: stimulus queues expected responses and
// memory requests, independent monitors pop and compare them.
module tb_param_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        from_cpu_inst_req_valid = 1'b0;
    logic [31:0] from_cpu_inst_req_addr = '0;
    logic        to_cpu_inst_req_ready;
    logic        to_cpu_cache_rsp_valid;
    logic [31:0] to_cpu_cache_rsp_data;
    logic        from_cpu_cache_rsp_ready = 1'b1;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready = 1'b0;
    logic        from_mem_rd_rsp_valid = 1'b0;
    logic [31:0] from_mem_rd_rsp_data = '0;
    logic        from_mem_rd_rsp_last = 1'b0;
    logic        to_mem_rd_rsp_ready;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic [31:0] hit_cnt, miss_cnt;

    param_icache dut (
        .clk                      (clk),
        .rst                      (rst),
        .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
        .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
        .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
        .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
        .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
        .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
        .to_mem_rd_req_valid      (to_mem_rd_req_valid),
        .to_mem_rd_req_addr       (to_mem_rd_req_addr),
        .from_mem_rd_req_ready    (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready),
        .flush_req                (flush_req),
        .flush_done               (flush_done),
        .hit_cnt                  (hit_cnt),
        .miss_cnt                 (miss_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_rsp_cyc = 0;
    int          mem_reqs = 0;
    int          stall_n = 0;
    int          abort_n = 0;
    bit          aborted = 1'b0;
    logic [31:0] exp_rsp [$];
    logic [31:0] exp_mem [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: word at byte address a holds (a >> 2) + 0x60.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
        else $display("ok   %s = %h", name, act);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && to_cpu_cache_rsp_valid && from_cpu_cache_rsp_ready) begin
            vectors++;
            last_rsp_cyc = cyc;
            if (exp_rsp.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got %h expected none", to_cpu_cache_rsp_data);
            end else begin
                logic [31:0] e;
                e = exp_rsp.pop_front();
                if (to_cpu_cache_rsp_data !== e) begin
                    miscompares++;
                    $display("FAIL rsp_data: got %h expected %h", to_cpu_cache_rsp_data, e);
                end else begin
                    $display("rsp  data=%h", to_cpu_cache_rsp_data);
                end
            end
        end
    end

    // Memory model and request monitor.
    initial begin : mem_model
        logic [31:0] a;
        int nb;
        forever begin
            @(negedge clk);
            if (!rst && to_mem_rd_req_valid) begin
                a = to_mem_rd_req_addr;
                mem_reqs++;
                vectors++;
                if (exp_mem.size() == 0) begin
                    miscompares++;
                    $display("FAIL mem_req_unexpected: got %h expected none", a);
                end else begin
                    logic [31:0] e;
                    e = exp_mem.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL mem_req_addr: got %h expected %h", a, e);
                    end else $display("mreq addr=%h", a);
                end
                for (int s = 1; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_req_valid", {31'b0, to_mem_rd_req_valid}, 32'd1);
                    chk("stall_req_addr", to_mem_rd_req_addr, a);
                    chk("stall_rsp_ready", {31'b0, to_mem_rd_rsp_ready}, 32'd0);
                end
                from_mem_rd_req_ready = 1'b1;
                @(posedge clk);
                #1 from_mem_rd_req_ready = 1'b0;
                nb = (abort_n > 0) ? abort_n : 8;
                for (int i = 0; i < nb; i++) begin
                    from_mem_rd_rsp_valid = 1'b1;
                    from_mem_rd_rsp_data  = mem_word(a + 32'(4 * i));
                    from_mem_rd_rsp_last  = (abort_n == 0) && (i == 7);
                    @(posedge clk);
                    #1;
                end
                from_mem_rd_rsp_valid = 1'b0;
                from_mem_rd_rsp_last  = 1'b0;
                if (abort_n > 0) aborted = 1'b1;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] exp_d, input bit miss);
        bit ok;
        ok = 1'b0;
        exp_rsp.push_back(exp_d);
        if (miss) exp_mem.push_back(a & ~32'h1F);
        @(negedge clk);
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = a;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (to_cpu_inst_req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1 from_cpu_inst_req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_rsp.size() != 0) chk("rsp_timeout", 32'(exp_rsp.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d, input bit miss);
        issue(a, exp_d, miss);
        wait_rsp();
    endtask

    initial begin
        int k;
        int mreq0;
        #1;
        chk("rst_mem_rsp_ready", {31'b0, to_mem_rd_rsp_ready}, 32'd1);
        chk("rst_cpu_req_ready", {31'b0, to_cpu_inst_req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, to_cpu_cache_rsp_valid}, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_mem_rsp_ready", {31'b0, to_mem_rd_rsp_ready}, 32'd0);

        // Cold miss, then hit with two-cycle latency and no memory traffic.
        fetch(32'h0000_0104, 32'h0000_00A1, 1'b1);
        chk("miss_cnt_t1", miss_cnt, 32'd1);
        mreq0 = mem_reqs;
        fetch(32'h0000_0104, 32'h0000_00A1, 1'b0);
        chk("hit_latency", 32'(last_rsp_cyc - acc_cyc), 32'd2);
        chk("hit_cnt_t2", hit_cnt, 32'd1);
        chk("hit_no_memreq", 32'(mem_reqs - mreq0), 32'd0);

        // Fill set 0, evict way 0, original tag misses again.
        fetch(32'h0000_0200, 32'h0000_00E0, 1'b1);
        fetch(32'h0000_0300, 32'h0000_0120, 1'b1);
        fetch(32'h0000_0400, 32'h0000_0160, 1'b1);
        fetch(32'h0000_0500, 32'h0000_01A0, 1'b1);
        fetch(32'h0000_0104, 32'h0000_00A1, 1'b1);
        fetch(32'h0000_0308, 32'h0000_0122, 1'b0);
        chk("miss_cnt_t3", miss_cnt, 32'd6);
        chk("hit_cnt_t3", hit_cnt, 32'd2);

        // Flush wins over a simultaneous fetch.
        @(negedge clk);
        flush_req = 1'b1;
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = 32'h0000_0300;
        #1 chk("flush_blocks_ready", {31'b0, to_cpu_inst_req_ready}, 32'd0);
        @(posedge clk);
        #1 flush_req = 1'b0;
        from_cpu_inst_req_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (flush_done) k = i;
        end
        chk("flush_cycles", 32'(k), 32'd8);
        @(negedge clk);
        chk("flush_done_pulse", {31'b0, flush_done}, 32'd0);
        fetch(32'h0000_0300, 32'h0000_0120, 1'b1);
        chk("miss_cnt_t4", miss_cnt, 32'd7);

        // Memory request held off for five cycles.
        stall_n = 5;
        fetch(32'h0000_06C0, 32'h0000_0210, 1'b1);
        stall_n = 0;
        chk("miss_cnt_t5", miss_cnt, 32'd8);

        // Reset in the middle of a refill.
        abort_n = 3;
        issue(32'h0000_07E4, 32'h0000_0259, 1'b1);
        k = 0;
        while (!aborted && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reached", {31'b0, aborted}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        exp_rsp.delete();
        abort_n = 0;
        #1;
        chk("midrst_mem_rsp_ready", {31'b0, to_mem_rd_rsp_ready}, 32'd1);
        chk("midrst_req_valid", {31'b0, to_mem_rd_req_valid}, 32'd0);
        chk("midrst_miss_cnt", miss_cnt, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fetch(32'h0000_07E4, 32'h0000_0259, 1'b1);
        chk("miss_cnt_t6", miss_cnt, 32'd1);
        chk("hit_cnt_t6", hit_cnt, 32'd0);

        repeat (4) @(negedge clk);
        chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
